data_mem_sync: RTL and testbench
================================

Name: data_mem_sync

Overview:
Parametrised synchronous data memory, successor to the 8x256 data_mem. Adds a req/ready handshake, byte-lane write enables and a registered read with a valid strobe. Also flags out-of-range addresses and runs a self-clearing init sequence after reset or on request. Sits between the CPU datapath and load/store unit as the data store.

Parameters:
DATA_W, 8, data word width in bits; must be a multiple of 8.
ADDR_W, 8, address bus width in bits.
DEPTH, 256, number of words implemented; 1 <= DEPTH <= 2**ADDR_W.
(derived) BE_W = DATA_W/8, number of byte lanes.

Ports:
clk  input  1  system clock, all state updates on rising edge.
rst_n  input  1  asynchronous active-low reset.
clear  input  1  synchronous request to re-zero the whole memory.
req  input  1  access request, qualified by ready.
r_w  input  1  1 = write, 0 = read.
address_bus  input  ADDR_W  word address.
data_in  input  DATA_W  write data.
byte_en  input  BE_W  per-byte write enable; bit i covers data_in[8i+7:8i].
ready  output  1  memory accepts a request this cycle.
data_out  output  DATA_W  registered read data.
rd_valid  output  1  one-cycle pulse: data_out holds the result of the read accepted last cycle.
addr_err  output  1  one-cycle pulse: the access accepted last cycle had address_bus >= DEPTH.
init_done  output  1  high once clearing has finished; low during INIT.

Behaviour:
- Reset (rst_n=0, asynchronous) sets ready=0, data_out=0, rd_valid=0, addr_err=0 and init_done=0. The FSM goes to INIT and the clear counter goes to 0. Array contents are not reset directly; INIT zeroes them.
- FSM states: INIT and RUN.
- INIT writes 0 to word[cnt] each cycle, then increments cnt. After writing word DEPTH-1 the FSM moves to RUN. The first RUN cycle has ready=1 and init_done=1, so INIT lasts exactly DEPTH cycles after rst_n rises.
- In INIT, req is ignored: no accept, no rd_valid, no addr_err.
- In RUN, clear=1 at an edge moves the FSM to INIT with cnt=0. A req in that same cycle is not accepted (clear wins). ready and init_done fall in the next cycle.
- ready is a registered state flag: it is 1 exactly when the state is RUN. Accept = req & ready & ~clear. Single-cycle accept; no back-pressure inside RUN.
- Write accept with address < DEPTH: for each set byte_en[i], byte i of word[address] takes data_in byte i at that edge. Unset lanes keep their value. byte_en=0 is a legal no-op write. rd_valid stays 0; data_out is unchanged.
- Read accept with address < DEPTH: data_out takes word[address] at that edge. rd_valid=1 for exactly the following cycle. Latency is 1 cycle.
- Back-to-back reads give rd_valid high for consecutive cycles.
- A write followed by a read of the same address in the next cycle returns the newly written data.
- data_out holds the last read value until the next accepted read, init or reset. INIT does not alter data_out.
- Out-of-range access (address >= DEPTH, only possible when DEPTH < 2**ADDR_W):
  - write: array is unchanged; addr_err pulses for 1 cycle.
  - read: data_out is set to 0, rd_valid and addr_err both pulse for 1 cycle.
- Reset asserted mid-INIT or mid-RUN aborts immediately. Any in-flight rd_valid or addr_err pulse is dropped, and INIT restarts from word 0.
- Address wrap: none. Addresses are absolute and are not taken modulo DEPTH.

Test Plan:
1. Reset and init, DEPTH=16: hold rst_n=0 for 3 cycles, then release. Require ready=0 for exactly 16 cycles, then ready=1 and init_done=1. A read of address 5 returns 0, with rd_valid one cycle after the accept.
2. Basic write/read, 8-bit: write 0x01 to address 0 and 0x07 to address 1, then read both back to back. Require data_out 0x01 then 0x07 on consecutive cycles, with rd_valid high both cycles.
3. Byte lanes, DATA_W=32: write 0xAABBCCDD with byte_en=1111 to address 3, then write 0x11223344 with byte_en=0101. A read of address 3 must return 0xAA22CC44.
4. Out of range, DEPTH=200: write 0x55 to address 210, then read address 210. Require addr_err to pulse after each access and the read to return data_out=0 with rd_valid=1. A read of address 199 is unaffected.
5. Clear collision: write 0x3C to address 9. Assert clear for one cycle together with a read request to address 9. Require no rd_valid, ready low for DEPTH cycles, and a later read of address 9 returning 0x00.
6. Mid-operation reset: pull rst_n low during INIT at cnt=7 and again in the same cycle as an accepted read. Require all outputs to be 0 immediately, no rd_valid pulse, and INIT to restart with a full DEPTH-cycle count.

Source files
------------

// File: rtl/data_mem_sync_if.sv
// Request/response bus of the synchronous data memory.
// The CPU side is the master and the memory is the slave.
interface data_mem_sync_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  localparam int BE_W = DATA_W / 8;

  logic              req;
  logic              r_w;
  logic [ADDR_W-1:0] address_bus;
  logic [DATA_W-1:0] data_in;
  logic [BE_W-1:0]   byte_en;
  logic              ready;
  logic [DATA_W-1:0] data_out;
  logic              rd_valid;
  logic              addr_err;

  modport master (
    output req, r_w, address_bus, data_in, byte_en,
    input  ready, data_out, rd_valid, addr_err
  );

  modport slave (
    input  req, r_w, address_bus, data_in, byte_en,
    output ready, data_out, rd_valid, addr_err
  );
endinterface

// File: rtl/data_mem_sync.sv
// Synchronous byte-lane data memory with registered read,
// range checking and a self-clearing init sweep.
module data_mem_sync #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic init_done,
  data_mem_sync_if.slave bus
);
  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEPTH - 1);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  typedef enum logic {
    INIT,
    RUN
  } state_t;

  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] dout_q;
  logic rd_valid_q;
  logic addr_err_q;
  logic [DATA_W-1:0] mem [DEPTH];

  logic run;
  logic accept;
  logic in_range;
  logic [CNT_W-1:0] idx;

  assign run      = (state_q == RUN);
  assign accept   = bus.req & run & ~clear;
  assign in_range = {1'b0, bus.address_bus} < DEPTH_L;
  assign idx      = bus.address_bus[CNT_W-1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      INIT: begin
        if (cnt_q == LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (clear) begin
          state_d = INIT;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = INIT;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Array has no reset; the INIT sweep zeroes it instead.
  always_ff @(posedge clk) begin
    if (state_q == INIT) begin
      mem[cnt_q] <= '0;
    end else if (accept && bus.r_w && in_range) begin
      for (int i = 0; i < BE_W; i++) begin
        if (bus.byte_en[i]) begin
          mem[idx][8*i +: 8] <= bus.data_in[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q     <= '0;
      rd_valid_q <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      rd_valid_q <= accept & ~bus.r_w;
      addr_err_q <= accept & ~in_range;
      if (accept && !bus.r_w) begin
        dout_q <= in_range ? mem[idx] : '0;
      end
    end
  end

  assign bus.ready    = run;
  assign bus.data_out = dout_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.addr_err = addr_err_q;
  assign init_done    = run;
endmodule

// File: tb/tb_data_mem_sync.sv
// Scoreboard bench for data_mem_sync: 32-bit words, 16 entries
// behind an 8-bit address, so out-of-range addresses exist.
module tb_data_mem_sync;
  localparam int DW = 32;
  localparam int AW = 8;
  localparam int DEPTH = 16;

  typedef struct packed {
    logic          rd;
    logic          err;
    logic [DW-1:0] d;
  } sb_t;

  logic clk;
  logic rst_n;
  logic clear;
  logic init_done;

  data_mem_sync_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  data_mem_sync #(
    .DATA_W(DW),
    .ADDR_W(AW),
    .DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .init_done(init_done),
    .bus      (bus)
  );

  int n_chk = 0;
  int n_err = 0;
  sb_t sb[$];
  sb_t mon_e;
  logic [DW-1:0] model [DEPTH];
  logic [DW-1:0] last_rd;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [DW-1:0] got,
                       input logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Every access pushes its expected response; idle cycles must be quiet.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      check("rd_valid", DW'(bus.rd_valid), DW'(mon_e.rd));
      check("addr_err", DW'(bus.addr_err), DW'(mon_e.err));
      if (mon_e.rd) check("data_out", bus.data_out, mon_e.d);
    end else begin
      check("idle_rd_valid", DW'(bus.rd_valid), '0);
      check("idle_addr_err", DW'(bus.addr_err), '0);
    end
  end

  task automatic model_zero();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  task automatic acc(input logic rw, input logic [AW-1:0] a,
                     input logic [DW-1:0] d, input logic [3:0] be);
    sb_t e;
    @(negedge clk);
    bus.req = 1'b1;
    bus.r_w = rw;
    bus.address_bus = a;
    bus.data_in = d;
    bus.byte_en = be;
    e.rd  = ~rw;
    e.err = (a >= AW'(DEPTH));
    e.d   = '0;
    if (a < AW'(DEPTH)) begin
      if (rw) begin
        for (int i = 0; i < 4; i++)
          if (be[i]) model[a[3:0]][8*i +: 8] = d[8*i +: 8];
      end else begin
        e.d = model[a[3:0]];
      end
    end
    if (!rw) last_rd = e.d;
    sb.push_back(e);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d,
                    input logic [3:0] be);
    acc(1'b1, a, d, be);
  endtask

  task automatic rd(input logic [AW-1:0] a);
    acc(1'b0, a, '0, 4'h0);
  endtask

  task automatic idle();
    @(negedge clk);
    bus.req = 1'b0;
  endtask

  task automatic wait_init(input string tag);
    int n = 0;
    while (!bus.ready && n < 64) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(tag, DW'(n), DW'(DEPTH));
    check({tag, "_done"}, DW'(init_done), DW'(1));
  endtask

  task automatic check_zero_outs(input string tag);
    check({tag, "_ready"}, DW'(bus.ready), '0);
    check({tag, "_init_done"}, DW'(init_done), '0);
    check({tag, "_data_out"}, bus.data_out, '0);
    check({tag, "_rd_valid"}, DW'(bus.rd_valid), '0);
    check({tag, "_addr_err"}, DW'(bus.addr_err), '0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    clear = 1'b0;
    bus.req = 1'b0;
    bus.r_w = 1'b0;
    bus.address_bus = '0;
    bus.data_in = '0;
    bus.byte_en = '0;
    last_rd = '0;
    model_zero();

    repeat (3) @(posedge clk);
    #1;
    check_zero_outs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    wait_init("init_len");

    rd(8'd5);
    wr(8'd0, 32'h01, 4'b0001);
    wr(8'd1, 32'h07, 4'b0001);
    rd(8'd0);
    rd(8'd1);
    wr(8'd3, 32'hAABBCCDD, 4'b1111);
    wr(8'd3, 32'h11223344, 4'b0101);
    rd(8'd3);
    wr(8'd1, 32'hFFFFFFFF, 4'b0000);
    rd(8'd1);
    wr(8'd15, 32'h99, 4'b0001);
    wr(8'd210, 32'h55, 4'b1111);
    rd(8'd210);
    rd(8'd16);
    rd(8'd15);
    idle();
    repeat (2) @(negedge clk);
    check("data_out_hold", bus.data_out, last_rd);

    wr(8'd9, 32'h3C, 4'b0001);
    @(negedge clk);
    clear = 1'b1;
    bus.req = 1'b1;
    bus.r_w = 1'b0;
    bus.address_bus = 8'd9;
    @(posedge clk);
    #1;
    clear = 1'b0;
    check("clear_ready", DW'(bus.ready), '0);
    model_zero();
    wait_init("clear_len");
    bus.req = 1'b0;
    check("init_keeps_data_out", bus.data_out, last_rd);
    rd(8'd9);

    wr(8'd2, 32'h5A5A, 4'b0011);
    rd(8'd2);
    idle();
    @(negedge clk);
    bus.req = 1'b1;
    bus.r_w = 1'b0;
    bus.address_bus = 8'd2;
    rst_n = 1'b0;
    #1;
    check_zero_outs("rst_run");
    @(negedge clk);
    bus.req = 1'b0;
    rst_n = 1'b1;
    model_zero();
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_zero_outs("rst_init");
    @(negedge clk);
    rst_n = 1'b1;
    wait_init("reinit_len");
    rd(8'd2);
    idle();
    repeat (3) @(negedge clk);
    check("sb_drained", DW'(sb.size()), '0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end
endmodule
